sram_ctrl_param: RTL and testbench
==================================

# sram_ctrl_param

Parametrised SRAM controller between the MEM stage (or a cache line-fill unit) and the external asynchronous SRAM. It is the successor to the fixed 32-bit, fixed-latency controller. It adds configurable data/address width, programmable wait states, a base-address offset, and multi-word read bursts for line fills. Read data is registered, and request address and data are latched at acceptance.

## Interface
- `DW`, 32: SRAM and CPU word width in bits.
- `AW`, 17: SRAM word-address width.
- `WAIT_CYCLES`, 6: cycles per SRAM access (beat); legal range ≥ 1.
- `BURST_LEN`, 1: words per read request; power of two, ≥ 1. Writes are always 1 word.
- `BASE_ADDR`, 32'd1024: byte address mapped to SRAM word 0; multiple of 4.
- `clk` input 1: single clock, rising edge.
- `reset` input 1: synchronous, active-high.
- `write_en` input 1: write request; held by requester until `SRAM_ready` is high.
- `read_en` input 1: read request; held likewise.
- `address` input 32: byte address of the request.
- `writeData` input DW: write word.
- `readData` output BURST_LEN*DW: registered read result; beat k occupies bits [k*DW +: DW].
- `SRAM_ready` output 1: low while a request is pending or in progress.
- `SRAM_DQ` inout DW: SRAM data bus.
- `SRAM_ADDR` output AW: SRAM word address.
- `SRAM_WE_N` output 1: SRAM write enable, active-low.

## Operation
- States: IDLE, WRITE, READ, DONE.
- **IDLE**
  - `write_en` → WRITE. `write_en` has priority when both enables are high.
  - Else `read_en` → READ.
  - On acceptance, latch `address` and `writeData`; clear the wait counter and beat counter.
- **Address**
  - Word = `address[AW+1:2]` − `BASE_ADDR[AW+1:2]`, truncated to AW bits (wraps modulo 2^AW).
  - Reads align the word down to a BURST_LEN boundary. Beat k drives aligned + k, modulo 2^AW.
- **WRITE**
  - `SRAM_WE_N` = 0 and `SRAM_DQ` = latched data for exactly WAIT_CYCLES cycles, then → DONE.
- **READ**
  - `SRAM_DQ` = Z. Each beat lasts WAIT_CYCLES cycles.
  - On the last cycle of beat k, sample `SRAM_DQ` into `readData` word k.
  - After beat BURST_LEN−1 → DONE.
- **DONE**
  - `SRAM_ready` = 1 for one cycle, then → IDLE unconditionally.
  - Enables seen in DONE are ignored; the requester advances on this cycle.
- **Outside active phases**
  - `SRAM_WE_N` = 1 and `SRAM_DQ` = Z in IDLE, READ and DONE.
  - `SRAM_ADDR` holds its last value.
- **`readData` retention**
  - `readData` changes only on sampling edges.
  - It holds its value across writes and until the next read overwrites it.
  - Words of a burst update progressively; only the value at DONE is guaranteed.

## Timing
- **Reset values:** state IDLE, counters 0, `SRAM_WE_N` = 1, `SRAM_DQ` = Z, `SRAM_ADDR` = 0, `readData` = 0.
- **Reset with enables high:** `SRAM_ready` is low, because it is combinational in IDLE.
- **`SRAM_ready`** = !(IDLE && (`write_en` | `read_en`)) && state ≠ WRITE && state ≠ READ.
- **Write latency:** the accept cycle plus WAIT_CYCLES cycles with ready low, then ready high in DONE.
  - Default: ready low for 7 cycles, high on the 8th.
- **Read latency:** 1 + BURST_LEN*WAIT_CYCLES cycles with ready low.
- **Back-to-back requests:** minimum spacing is DONE then IDLE, so a new request is accepted 2 cycles after the previous one's last active cycle.
- **Counter widths:** wait counter `$clog2(WAIT_CYCLES+1)`, beat counter `$clog2(BURST_LEN+1)`. Neither may overflow at the maximum parameter values.
- **Reset mid-operation:**
  - Same edge: → IDLE, `SRAM_WE_N` = 1 and DQ released in the following cycle, `readData` cleared.
  - No partial DONE pulse is produced.
- **Enable drop mid-operation:** ignored; the latched request completes.

## Structure
- **Package `sram_ctrl_pkg`:**
  - state enum `sram_state_t` {IDLE, WRITE, READ, DONE};
  - default constants `SRAM_DW`, `SRAM_AW`, `SRAM_WAIT`, `SRAM_BASE`.
- **Sub-module `sram_wait_timer`:**
  - parametrised by WAIT_CYCLES;
  - inputs: `clk`, `reset`, clear, enable;
  - output: `last`, asserted on the final cycle of a beat;
  - instantiated once and reused for read and write beats.
- **Top level:** holds the FSM, beat counter, address/data latches, tristate driver and `readData` register.

## Test plan
- **Default write:** write_en, `address` = 0x400, `writeData` = 0xDEADBEEF.
  - Expect `SRAM_ADDR` = 0, `SRAM_WE_N` low for 6 cycles with DQ = 0xDEADBEEF.
  - Expect ready low 7 cycles, high on the 8th.
- **Burst read:** BURST_LEN = 2, WAIT_CYCLES = 3, `address` = 0x40C, SRAM model returning word n = n + 0x100.
  - Expect `SRAM_ADDR` 2 then 3.
  - Expect `readData` = {0x103, 0x102}, ready low 7 cycles.
- **Simultaneous enables:** write_en and read_en both high.
  - Expect the WRITE path taken, and `readData` unchanged from its prior value 0x12345678.
- **Address wrap:** `address` = 0x3FC (below base).
  - Expect `SRAM_ADDR` = 0x1FFFF.
- **Reset mid-write:** reset asserted on the 3rd write cycle.
  - Next cycle: `SRAM_WE_N` = 1, DQ = Z, `readData` = 0.
  - A read issued after reset completes with normal latency.
- **Back-to-back reads:** enables held through DONE.
  - Expect exactly two accesses, with ready high for exactly one cycle between them.

Source files
------------

// File: rtl/sram_ctrl_pkg.sv
// Shared types and default constants for the parametrised SRAM controller.
package sram_ctrl_pkg;

   // Controller phases: wait for a request, drive a write beat, run read
   // beats, then present ready for one cycle.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      READ  = 2'd2,
      DONE  = 2'd3
   } sram_state_t;

   localparam int          SRAM_DW   = 32;
   localparam int          SRAM_AW   = 17;
   localparam int          SRAM_WAIT = 6;
   localparam logic [31:0] SRAM_BASE = 32'd1024;

endpackage

// File: rtl/sram_wait_timer.sv
// Beat timer: counts the cycles of one SRAM access and flags its final cycle.
// The same timer times every write beat and every read beat.
module sram_wait_timer #(
   parameter int WAIT_CYCLES = 6
) (
   input  logic clk,
   input  logic reset,
   input  logic clear_i,
   input  logic enable_i,
   output logic last_o
);

   localparam int            CW       = $clog2(WAIT_CYCLES + 1);
   localparam logic [CW-1:0] TERMINAL = CW'(WAIT_CYCLES - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   // Next count: restart on clear or after the final cycle, else advance while enabled.
   always_comb begin
      cnt_d = cnt_q;
      if (clear_i) begin
         cnt_d = '0;
      end else if (enable_i) begin
         if (cnt_q == TERMINAL) begin
            cnt_d = '0;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end else begin
         cnt_d = cnt_q;
      end
   end

   assign last_o = enable_i && !clear_i && (cnt_q == TERMINAL);

   // Cycle counter register.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/sram_ctrl_param.sv
// Parametrised SRAM controller: single-word writes, BURST_LEN-word reads,
// programmable wait states and a byte base address mapped to SRAM word 0.
module sram_ctrl_param
   import sram_ctrl_pkg::*;
#(
   parameter int          DW          = SRAM_DW,
   parameter int          AW          = SRAM_AW,
   parameter int          WAIT_CYCLES = SRAM_WAIT,
   parameter int          BURST_LEN   = 1,
   parameter logic [31:0] BASE_ADDR   = SRAM_BASE
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    write_en,
   input  logic                    read_en,
   input  logic [31:0]             address,
   input  logic [DW-1:0]           writeData,
   output logic [BURST_LEN*DW-1:0] readData,
   output logic                    SRAM_ready,
   inout  wire  [DW-1:0]           SRAM_DQ,
   output logic [AW-1:0]           SRAM_ADDR,
   output logic                    SRAM_WE_N
);

   localparam int            BW         = $clog2(BURST_LEN + 1);
   localparam logic [AW-1:0] BASE_WORD  = BASE_ADDR[AW+1:2];
   localparam logic [AW-1:0] ALIGN_MASK = ~AW'(BURST_LEN - 1);

   sram_state_t              state_q;
   logic [BW-1:0]            beat_q;
   logic [AW-1:0]            addr_q;
   logic [DW-1:0]            data_q;
   logic                     we_n_q;
   logic                     oe_q;
   logic [BURST_LEN*DW-1:0]  rdata_q;

   logic [AW-1:0]            word_d;
   logic [AW-1:0]            burst_word_d;
   logic                     timer_clear_s;
   logic                     timer_en_s;
   logic                     last_s;
   logic                     unused_addr_s;

   // Word address relative to the base; wraps modulo 2^AW. Bursts start aligned.
   assign word_d        = address[AW+1:2] - BASE_WORD;
   assign burst_word_d  = word_d & ALIGN_MASK;
   assign unused_addr_s = ^address;

   assign timer_clear_s = (state_q == IDLE) || (state_q == DONE);
   assign timer_en_s    = (state_q == WRITE) || (state_q == READ);

   sram_wait_timer #(
      .WAIT_CYCLES (WAIT_CYCLES)
   ) u_timer (
      .clk      (clk),
      .reset    (reset),
      .clear_i  (timer_clear_s),
      .enable_i (timer_en_s),
      .last_o   (last_s)
   );

   // Ready drops combinationally as soon as a request is seen in IDLE.
   assign SRAM_ready = !((state_q == IDLE) && (write_en || read_en))
                       && (state_q != WRITE) && (state_q != READ);

   assign SRAM_ADDR = addr_q;
   assign SRAM_WE_N = we_n_q;
   assign SRAM_DQ   = oe_q ? data_q : {DW{1'bz}};
   assign readData  = rdata_q;

   // Controller FSM with registered SRAM strobes, address and read data.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         beat_q  <= '0;
         addr_q  <= '0;
         data_q  <= '0;
         we_n_q  <= 1'b1;
         oe_q    <= 1'b0;
         rdata_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (write_en) begin
                  state_q <= WRITE;
                  addr_q  <= word_d;
                  data_q  <= writeData;
                  beat_q  <= '0;
                  we_n_q  <= 1'b0;
                  oe_q    <= 1'b1;
               end else if (read_en) begin
                  state_q <= READ;
                  addr_q  <= burst_word_d;
                  data_q  <= writeData;
                  beat_q  <= '0;
               end else begin
                  state_q <= IDLE;
               end
            end
            WRITE: begin
               if (last_s) begin
                  state_q <= DONE;
                  we_n_q  <= 1'b1;
                  oe_q    <= 1'b0;
               end else begin
                  state_q <= WRITE;
               end
            end
            READ: begin
               if (last_s) begin
                  for (int k = 0; k < BURST_LEN; k++) begin
                     if (beat_q == BW'(k)) begin
                        rdata_q[k*DW +: DW] <= SRAM_DQ;
                     end
                  end
                  if (beat_q == BW'(BURST_LEN - 1)) begin
                     state_q <= DONE;
                  end else begin
                     beat_q <= beat_q + BW'(1);
                     addr_q <= addr_q + AW'(1);
                  end
               end else begin
                  state_q <= READ;
               end
            end
            DONE: begin
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sram_ctrl_param.sv
// Scoreboard bench for sram_ctrl_param (BURST_LEN = 2, WAIT_CYCLES = 3).
module tb_sram_ctrl_param;

   localparam int          DW   = 32;
   localparam int          AW   = 17;
   localparam int          WC   = 3;
   localparam int          BL   = 2;
   localparam int unsigned BASE = 1024;
   localparam int unsigned WRAP = 2 ** AW;

   typedef struct {
      bit          is_wr;
      int          low;
      int unsigned a0;
      int          nbeat;
      logic [31:0] wdata;
      logic [63:0] rd;
      bit          b2b;
   } exp_t;

   logic              clk = 1'b0;
   logic              reset;
   logic              write_en;
   logic              read_en;
   logic [31:0]       address;
   logic [DW-1:0]     writeData;
   logic [BL*DW-1:0]  readData;
   logic              SRAM_ready;
   wire  [DW-1:0]     SRAM_DQ;
   logic [AW-1:0]     SRAM_ADDR;
   logic              SRAM_WE_N;

   int                n_cmp  = 0;
   int                n_fail = 0;
   exp_t              exp_q[$];
   logic [31:0]       ref_mem[int unsigned];
   logic [63:0]       last_rd;
   logic [31:0]       sram_mem[int unsigned];
   logic [31:0]       sram_rd;
   logic              tb_oe;

   sram_ctrl_param #(
      .DW (DW), .AW (AW), .WAIT_CYCLES (WC), .BURST_LEN (BL), .BASE_ADDR (32'd1024)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .write_en   (write_en),
      .read_en    (read_en),
      .address    (address),
      .writeData  (writeData),
      .readData   (readData),
      .SRAM_ready (SRAM_ready),
      .SRAM_DQ    (SRAM_DQ),
      .SRAM_ADDR  (SRAM_ADDR),
      .SRAM_WE_N  (SRAM_WE_N)
   );

   always #5 clk = ~clk;

   // SRAM device model: drives the bus only while the controller is busy and not writing.
   assign tb_oe   = SRAM_WE_N && !SRAM_ready;
   assign SRAM_DQ = tb_oe ? sram_rd : {DW{1'bz}};

   initial begin
      sram_rd = 32'h0;
      forever begin
         @(negedge clk);
         if (SRAM_WE_N === 1'b0) sram_mem[int'(SRAM_ADDR)] = SRAM_DQ;
         sram_rd = sram_mem.exists(int'(SRAM_ADDR)) ? sram_mem[int'(SRAM_ADDR)]
                                                   : 32'(SRAM_ADDR) + 32'h100;
      end
   end

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
      n_cmp++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, want, $time);
      end
   endtask

   // Reference memory contents as seen by the requester.
   function automatic logic [31:0] ref_word(input int unsigned a);
      return ref_mem.exists(a) ? ref_mem[a] : a + 32'h100;
   endfunction

   // Issue one request, push its expected outcome, wait (bounded) for ready.
   task automatic issue(input bit wr, input bit both, input logic [31:0] addr,
                        input logic [31:0] wd, input bit keep, input bit drop, input bit b2b);
      exp_t        e;
      int unsigned w;
      bit          done;
      w = ((addr / 4) - (BASE / 4)) % WRAP;
      e.is_wr = wr;
      e.wdata = wd;
      e.b2b   = b2b;
      if (wr) begin
         e.low   = 1 + WC;
         e.a0    = w;
         e.nbeat = 1;
         ref_mem[w] = wd;
         e.rd    = last_rd;
      end else begin
         e.low   = 1 + BL * WC;
         e.a0    = (w / BL) * BL;
         e.nbeat = BL;
         for (int k = 0; k < BL; k++) e.rd[k*32 +: 32] = ref_word((e.a0 + k) % WRAP);
         last_rd = e.rd;
      end
      exp_q.push_back(e);
      write_en  = wr;
      read_en   = !wr || both;
      address   = addr;
      writeData = wd;
      done = 1'b0;
      for (int i = 0; i < 100 && !done; i++) begin
         @(negedge clk);
         if (SRAM_ready) done = 1'b1;
         else if (drop && i == 0) begin
            @(posedge clk); #1;
            write_en = 1'b0;
            read_en  = 1'b0;
         end
      end
      if (!done) begin
         n_cmp++;
         n_fail++;
         $display("FAIL ready_timeout: ready never rose for address %h", addr);
      end
      @(posedge clk); #1;
      if (!keep) begin
         write_en = 1'b0;
         read_en  = 1'b0;
      end
   endtask

   // Monitor: measures each busy period and compares it with the queued expectation.
   initial begin
      int          low_cnt  = 0;
      int          high_cnt = 1000;
      int          gap      = 0;
      int          we_cnt   = 0;
      bit          dq_err   = 1'b0;
      logic [AW-1:0] seen_q[$];
      exp_t        e;
      forever begin
         @(negedge clk);
         if (reset) begin
            low_cnt  = 0;
            high_cnt = 1000;
            exp_q.delete();
            seen_q.delete();
         end else if (!SRAM_ready) begin
            if (low_cnt == 0) begin
               gap    = high_cnt;
               we_cnt = 0;
               dq_err = 1'b0;
               seen_q.delete();
            end else begin
               if (seen_q.size() == 0 || seen_q[$] != SRAM_ADDR) seen_q.push_back(SRAM_ADDR);
               if (SRAM_WE_N === 1'b0) begin
                  we_cnt++;
                  if (exp_q.size() > 0 && SRAM_DQ !== exp_q[0].wdata) dq_err = 1'b1;
               end
            end
            low_cnt++;
         end else begin
            if (low_cnt > 0) begin
               if (exp_q.size() == 0) begin
                  n_cmp++;
                  n_fail++;
                  $display("FAIL unexpected_txn: busy period of %0d cycles with nothing issued", low_cnt);
               end else begin
                  e = exp_q.pop_front();
                  chk("ready_low_cycles", 64'(low_cnt), 64'(e.low));
                  chk("beat_count", 64'(seen_q.size()), 64'(e.nbeat));
                  for (int k = 0; k < seen_q.size() && k < e.nbeat; k++)
                     chk("sram_addr", 64'(seen_q[k]), 64'((e.a0 + k) % WRAP));
                  chk("readData", readData, e.rd);
                  chk("we_n_low_cycles", 64'(we_cnt), e.is_wr ? 64'(WC) : 64'd0);
                  chk("write_dq", 64'(dq_err), 64'd0);
                  chk("done_we_n", 64'(SRAM_WE_N), 64'd1);
                  chk("done_dq_z", 64'(SRAM_DQ === {DW{1'bz}}), 64'd1);
                  if (e.b2b) chk("b2b_ready_gap", 64'(gap), 64'd1);
               end
               low_cnt  = 0;
               high_cnt = 0;
            end
            high_cnt++;
         end
      end
   end

   // Stimulus: reset checks, directed cases, reset mid-write, then random traffic.
   initial begin
      bit prev_keep;
      reset     = 1'b1;
      write_en  = 1'b0;
      read_en   = 1'b0;
      address   = 32'h0;
      writeData = 32'h0;
      last_rd   = 64'h0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_we_n", 64'(SRAM_WE_N), 64'd1);
      chk("rst_addr", 64'(SRAM_ADDR), 64'd0);
      chk("rst_readData", readData, 64'd0);
      chk("rst_ready", 64'(SRAM_ready), 64'd1);
      chk("rst_dq_z", 64'(SRAM_DQ === {DW{1'bz}}), 64'd1);
      read_en = 1'b1;
      #1;
      chk("rst_ready_with_en", 64'(SRAM_ready), 64'd0);
      read_en = 1'b0;
      @(posedge clk); #1;
      reset = 1'b0;

      issue(1'b1, 1'b0, 32'h400, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0);
      issue(1'b0, 1'b0, 32'h40C, 32'h0,        1'b0, 1'b1, 1'b0);
      issue(1'b1, 1'b0, 32'h410, 32'h12345678, 1'b0, 1'b0, 1'b0);
      issue(1'b0, 1'b0, 32'h410, 32'h0,        1'b0, 1'b0, 1'b0);
      issue(1'b1, 1'b1, 32'h420, 32'hCAFEF00D, 1'b0, 1'b0, 1'b0);
      issue(1'b1, 1'b0, 32'h3FC, 32'h0BADF00D, 1'b0, 1'b0, 1'b0);
      issue(1'b0, 1'b0, 32'h3FC, 32'h0,        1'b0, 1'b0, 1'b0);
      issue(1'b0, 1'b0, 32'h400, 32'h0,        1'b1, 1'b0, 1'b0);
      issue(1'b0, 1'b0, 32'h418, 32'h0,        1'b0, 1'b0, 1'b1);

      write_en  = 1'b1;
      read_en   = 1'b0;
      address   = 32'h500;
      writeData = 32'hA5A5A5A5;
      @(negedge clk);
      repeat (3) begin @(posedge clk); #1; end
      chk("mid_write_we_n", 64'(SRAM_WE_N), 64'd0);
      reset    = 1'b1;
      write_en = 1'b0;
      @(posedge clk); #1;
      @(negedge clk);
      chk("after_rst_we_n", 64'(SRAM_WE_N), 64'd1);
      chk("after_rst_dq_z", 64'(SRAM_DQ === {DW{1'bz}}), 64'd1);
      chk("after_rst_readData", readData, 64'd0);
      chk("after_rst_ready", 64'(SRAM_ready), 64'd1);
      reset   = 1'b0;
      last_rd = 64'h0;
      @(posedge clk); #1;
      issue(1'b1, 1'b0, 32'h430, 32'h13579BDF, 1'b0, 1'b0, 1'b0);
      issue(1'b0, 1'b0, 32'h40C, 32'h0,        1'b0, 1'b0, 1'b0);

      prev_keep = 1'b0;
      for (int i = 0; i < 40; i++) begin
         bit wr;
         bit both;
         bit keep;
         wr   = 1'($urandom_range(0, 1));
         both = wr && ($urandom_range(0, 3) == 0);
         keep = (i < 39) && ($urandom_range(0, 3) == 0);
         issue(wr, both, 32'h600 + 32'($urandom_range(0, 127) * 4) + 32'($urandom_range(0, 3)),
               $urandom, keep, 1'b0, prev_keep);
         prev_keep = keep;
      end

      repeat (5) @(posedge clk);
      chk("leftover_expectations", 64'(exp_q.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   // Global time bound.
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

endmodule
